scoreboard_hazard_unit: RTL and testbench
=========================================

// Module: scoreboard_hazard_unit
// PURPOSE
//  Parametrised successor to the pipeline's load-use hazard detector. It holds a per-register
//  scoreboard of in-flight writes with their remaining latency, so multi-cycle ops are covered.
//  It also stalls branches in ID whose operands are not ready, and freezes the whole pipe while
//  data memory is busy. Sits beside ID; drives PC/IF_ID write enables, IF_ID flush, ID_EX bubble.
// PARAMETERS
//  REG_ADDR_W  5   register index width
//  NUM_REGS    32  scoreboard entries (2**REG_ADDR_W)
//  LOAD_LAT    1   cycles a load result is unavailable to ID after issue
//  MUL_LAT     3   cycles a multi-cycle ALU result is unavailable after issue
//  CNT_W       2   countdown width; must hold max(LOAD_LAT,MUL_LAT)
//  STALL_CNT_W 16  perf stall-counter width
// PORTS
//  clk_i         in   1            clock
//  rst_i         in   1            synchronous reset, active high
//  id_rs_i       in   REG_ADDR_W   ID source A
//  id_rt_i       in   REG_ADDR_W   ID source B
//  id_uses_rt_i  in   1            source B is actually read
//  id_rd_i       in   REG_ADDR_W   ID destination
//  id_wr_i       in   1            ID instruction writes id_rd_i
//  id_class_i    in   2            latency class: 0 ALU, 1 LOAD, 2 MUL, 3 reserved (= ALU)
//  id_branch_i   in   1            ID holds a conditional branch (compares in ID)
//  id_taken_i    in   1            branch compare result (valid when operands are ready)
//  id_jump_i     in   1            ID holds a jump
//  dmem_busy_i   in   1            MEM stage waiting on data memory
//  pc_write_o    out  1            PC load enable
//  ifid_write_o  out  1            IF_ID load enable
//  ifid_flush_o  out  1            zero IF_ID on next edge
//  idex_bubble_o out  1            insert zero control word into ID_EX
//  freeze_o      out  1            hold all pipeline registers
//  stall_cnt_o   out  STALL_CNT_W  saturating count of stalled or frozen cycles
// BEHAVIOUR
//  - State: cnt[r] (CNT_W) per register; ex_rd/ex_vld = dest of the instruction issued last cycle.
//  - busy(r) = (r!=0) && cnt[r]!=0. Register 0 is never marked.
//  - data_stall = busy(rs) | (id_uses_rt & busy(rt)) | (id_wr & busy(rd)).
//    The busy(rd) term is the WAW guard.
//  - br_stall = id_branch & ex_vld & (rs==ex_rd | rt==ex_rd) & ex_rd!=0. The ID compare cannot
//    take an ALU result still in EX.
//  - stall = data_stall | br_stall. freeze = dmem_busy_i.
//  - Priority: rst > freeze > stall > normal.
//  - freeze: pc_write=0, ifid_write=0, bubble=0, flush=0. Counters and ex_* hold.
//  - stall: pc_write=0, ifid_write=0, bubble=1, flush=0. A stalled branch never flushes.
//  - normal: pc_write=1, ifid_write=1, bubble=0, flush = id_jump | (id_branch & id_taken).
//  - Issue occurs on a normal cycle with id_wr & id_rd!=0. At that edge cnt[id_rd] <= LAT(class),
//    with ALU=0. ex_rd<=id_rd, ex_vld<=id_wr; when not issuing, ex_vld<=0 (bubble or freeze hold).
//  - Each non-frozen edge: every nonzero cnt decrements by 1. A set at issue overrides the
//    decrement of the same entry.
//  - Latency: LOAD_LAT=1 gives exactly one bubble for back-to-back load-use; MUL_LAT=3 gives 3.
//  - stall_cnt_o increments on each stall or freeze cycle and saturates at all-ones.
//  - Reset (sync): all cnt=0, ex_vld=0, stall_cnt_o=0. While rst_i is high, all outputs are forced
//    0 combinationally. A reset mid-countdown discards pending entries.
//  - id_class 3 behaves as ALU.
// STRUCTURE
//  - Shared package: latency-class encoding (LC_ALU/LC_LOAD/LC_MUL) and a control-word-width constant.
//  - One sub-module sb_entry: CNT_W down-counter with load/hold/decrement, generated NUM_REGS-1 times.
// TESTING
//  1. Reset: rst_i=1 for 2 cycles -> all outputs 0. Release -> pc_write=1, ifid_write=1, stall_cnt=0.
//  2. lw $2 then add $3,$2,$4 -> 1 cycle of bubble=1/pc_write=0, then issue. stall_cnt=1.
//  3. mul $5 then add $6,$5,$5 -> 3 bubbles. Same sequence with dmem_busy=1 for 2 mid-cycles ->
//     counters hold, total 5 non-issue cycles.
//  4. add $7 then beq $7,$0 taken -> 1 br_stall cycle with flush=0, then flush=1 for 1 cycle.
//     Jump -> flush=1 immediately.
//  5. lw $0 then add using $0 -> no stall. mul $8 then addi $8 (WAW) -> stall until cnt[8]=0.
//  6. rst_i mid-way through a MUL_LAT countdown -> next dependent instruction issues without stall.
//     Force 2**16 stalls -> stall_cnt_o saturates at 0xFFFF.

Source files
------------

// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared types for the scoreboard hazard unit:
// latency classes, operating modes, control word.
package scoreboard_hazard_unit_pkg;

  typedef enum logic [1:0] {
    LC_ALU  = 2'd0,
    LC_LOAD = 2'd1,
    LC_MUL  = 2'd2,
    LC_RSVD = 2'd3
  } lat_class_e;

  typedef enum logic [1:0] {
    M_RESET,
    M_FREEZE,
    M_STALL,
    M_NORMAL
  } hz_mode_e;

  localparam int CTRL_W = 5;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic freeze;
  } hz_ctrl_t;

  // Reserved class falls back to single-cycle ALU timing.
  function automatic int lat_of(
    input lat_class_e c,
    input int         load_lat,
    input int         mul_lat
  );
    int lat;
    lat = 0;
    unique case (c)
      LC_LOAD: lat = load_lat;
      LC_MUL:  lat = mul_lat;
      default: lat = 0;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// ID-side request and pipeline control bundle
// between the decode stage and the hazard unit.
interface scoreboard_hazard_unit_if
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
);

  logic [REG_ADDR_W-1:0]  id_rs_i;
  logic [REG_ADDR_W-1:0]  id_rt_i;
  logic                   id_uses_rt_i;
  logic [REG_ADDR_W-1:0]  id_rd_i;
  logic                   id_wr_i;
  lat_class_e             id_class_i;
  logic                   id_branch_i;
  logic                   id_taken_i;
  logic                   id_jump_i;
  logic                   dmem_busy_i;
  logic                   pc_write_o;
  logic                   ifid_write_o;
  logic                   ifid_flush_o;
  logic                   idex_bubble_o;
  logic                   freeze_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i,
    output id_rd_i, id_wr_i, id_class_i,
    output id_branch_i, id_taken_i,
    output id_jump_i, dmem_busy_i,
    input  pc_write_o, ifid_write_o,
    input  ifid_flush_o, idex_bubble_o,
    input  freeze_o, stall_cnt_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i,
    input  id_rd_i, id_wr_i, id_class_i,
    input  id_branch_i, id_taken_i,
    input  id_jump_i, dmem_busy_i,
    output pc_write_o, ifid_write_o,
    output ifid_flush_o, idex_bubble_o,
    output freeze_o, stall_cnt_o
  );

endinterface

// File: rtl/scoreboard_hazard_unit_sb_entry.sv
// One scoreboard slot: remaining cycles until a
// pending write to its register is visible to ID.
module sb_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load on issue beats the per-cycle decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (hold_i) begin
      cnt_d = cnt_q;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Countdown register, cleared by sync reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard-based hazard unit beside ID: load/mul
// use stalls, WAW guard, branch stalls, dmem freeze.
module scoreboard_hazard_unit
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int NUM_REGS    = 2**REG_ADDR_W,
  parameter int LOAD_LAT    = 1,
  parameter int MUL_LAT     = 3,
  parameter int CNT_W       = 2,
  parameter int STALL_CNT_W = 16
) (
  input logic clk_i,
  input logic rst_i,
  scoreboard_hazard_unit_if.slave hz
);

  logic [CNT_W-1:0]       cnt [NUM_REGS];
  logic                   busy_rs;
  logic                   busy_rt;
  logic                   busy_rd;
  logic                   data_stall;
  logic                   br_stall;
  logic                   issue;
  logic [CNT_W-1:0]       lat_val;
  hz_mode_e               mode;
  hz_ctrl_t               ctrl;
  logic [STALL_CNT_W-1:0] stall_inc;

  logic [REG_ADDR_W-1:0]  ex_rd_q;
  logic [REG_ADDR_W-1:0]  ex_rd_d;
  logic                   ex_vld_q;
  logic                   ex_vld_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;

  // Register 0 is hardwired and never pending.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    sb_entry #(
      .CNT_W(CNT_W)
    ) u_entry (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .hold_i     (mode == M_FREEZE),
      .load_i     (issue &&
                   (hz.id_rd_i == REG_ADDR_W'(r))),
      .load_val_i (lat_val),
      .cnt_o      (cnt[r])
    );
  end

  // Hazard terms and mode selection, rst > freeze > stall.
  always_comb begin
    busy_rs = (hz.id_rs_i != '0) &&
              (cnt[hz.id_rs_i] != '0);
    busy_rt = (hz.id_rt_i != '0) &&
              (cnt[hz.id_rt_i] != '0);
    busy_rd = (hz.id_rd_i != '0) &&
              (cnt[hz.id_rd_i] != '0);
    data_stall = busy_rs ||
                 (hz.id_uses_rt_i && busy_rt) ||
                 (hz.id_wr_i && busy_rd);
    br_stall = hz.id_branch_i && ex_vld_q &&
               (ex_rd_q != '0) &&
               ((hz.id_rs_i == ex_rd_q) ||
                (hz.id_rt_i == ex_rd_q));
    if (rst_i)                       mode = M_RESET;
    else if (hz.dmem_busy_i)         mode = M_FREEZE;
    else if (data_stall || br_stall) mode = M_STALL;
    else                             mode = M_NORMAL;
    issue = (mode == M_NORMAL) && hz.id_wr_i &&
            (hz.id_rd_i != '0);
    lat_val = CNT_W'(lat_of(hz.id_class_i,
                            LOAD_LAT, MUL_LAT));
    stall_inc = (&stall_cnt_q) ? stall_cnt_q :
                stall_cnt_q + STALL_CNT_W'(1);
  end

  // Control word and next EX-dest / perf state per mode.
  always_comb begin
    ctrl        = '0;
    ex_rd_d     = ex_rd_q;
    ex_vld_d    = ex_vld_q;
    stall_cnt_d = stall_cnt_q;
    unique case (mode)
      M_RESET: begin
        ex_rd_d     = '0;
        ex_vld_d    = 1'b0;
        stall_cnt_d = '0;
      end
      M_FREEZE: begin
        ctrl.freeze = 1'b1;
        stall_cnt_d = stall_inc;
      end
      M_STALL: begin
        ctrl.idex_bubble = 1'b1;
        ex_vld_d         = 1'b0;
        stall_cnt_d      = stall_inc;
      end
      M_NORMAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.ifid_write = 1'b1;
        ctrl.ifid_flush = hz.id_jump_i ||
                          (hz.id_branch_i &&
                           hz.id_taken_i);
        ex_rd_d         = hz.id_rd_i;
        ex_vld_d        = issue;
      end
    endcase
  end

  // EX destination tracker and stall counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_rd_q     <= '0;
      ex_vld_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_rd_q     <= ex_rd_d;
      ex_vld_q    <= ex_vld_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.pc_write_o    = ctrl.pc_write;
  assign hz.ifid_write_o  = ctrl.ifid_write;
  assign hz.ifid_flush_o  = ctrl.ifid_flush;
  assign hz.idex_bubble_o = ctrl.idex_bubble;
  assign hz.freeze_o      = ctrl.freeze;
  assign hz.stall_cnt_o   = rst_i ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: directed
// vector table, random vs. model, saturation.
module tb_scoreboard_hazard_unit;
  import scoreboard_hazard_unit_pkg::*;

  logic clk;
  logic rst;

  scoreboard_hazard_unit_if hz ();

  scoreboard_hazard_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        ut;
    logic [4:0]  rd;
    logic        wr;
    logic [1:0]  cls;
    logic        br;
    logic        tk;
    logic        jmp;
    logic        busy;
    logic [4:0]  ctl;
    logic [15:0] sc;
  } vec_t;

  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] N  = 5'b11000;
  localparam logic [4:0] NF = 5'b11100;
  localparam logic [4:0] S  = 5'b00010;
  localparam logic [4:0] F  = 5'b00001;

  int n_tests;
  int n_fail;

  // Model: each register has the cycle index
  // (counting only non-frozen cycles) at which
  // its result becomes readable by ID.
  int avail [32];
  int tick;
  int last_tick;
  int last_rd;
  int scnt;

  function automatic vec_t mk(
    input logic rst_v, input int rs, input int rt,
    input logic ut, input int rd, input logic wr,
    input int cls, input logic br, input logic tk,
    input logic jmp, input logic busy,
    input logic [4:0] ctl, input int sc
  );
    vec_t v;
    v.rst = rst_v; v.rs = 5'(rs); v.rt = 5'(rt);
    v.ut = ut; v.rd = 5'(rd); v.wr = wr;
    v.cls = 2'(cls); v.br = br; v.tk = tk;
    v.jmp = jmp; v.busy = busy; v.ctl = ctl;
    v.sc = 16'(sc);
    return v;
  endfunction

  function automatic bit m_busy(input int r);
    return (r != 0) && (avail[r] > tick);
  endfunction

  function automatic int m_lat(input int cls);
    if (cls == 1) return 1;
    if (cls == 2) return 3;
    return 0;
  endfunction

  task automatic drive(input vec_t v);
    rst             = v.rst;
    hz.id_rs_i      = v.rs;
    hz.id_rt_i      = v.rt;
    hz.id_uses_rt_i = v.ut;
    hz.id_rd_i      = v.rd;
    hz.id_wr_i      = v.wr;
    hz.id_class_i   = lat_class_e'(v.cls);
    hz.id_branch_i  = v.br;
    hz.id_taken_i   = v.tk;
    hz.id_jump_i    = v.jmp;
    hz.dmem_busy_i  = v.busy;
  endtask

  task automatic check(
    input string nm,
    input logic [20:0] act,
    input logic [20:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got ctl=%b sc=%h want ctl=%b sc=%h",
               nm, $time, act[20:16], act[15:0],
               exp[20:16], exp[15:0]);
    end
  endtask

  task automatic step(
    input string       nm,
    input bit          tab_chk,
    input logic [4:0]  t_ctl,
    input logic [15:0] t_sc,
    input bit          mdl_chk
  );
    logic [4:0]  act_ctl;
    logic [4:0]  m_ctl;
    logic [15:0] m_sc;
    int rs, rt, rd, cls;
    bit stall, fl;
    @(negedge clk);
    act_ctl = {hz.pc_write_o, hz.ifid_write_o,
               hz.ifid_flush_o, hz.idex_bubble_o,
               hz.freeze_o};
    rs  = int'(hz.id_rs_i);
    rt  = int'(hz.id_rt_i);
    rd  = int'(hz.id_rd_i);
    cls = int'(hz.id_class_i);
    stall = m_busy(rs) ||
            (hz.id_uses_rt_i && m_busy(rt)) ||
            (hz.id_wr_i && m_busy(rd)) ||
            (hz.id_branch_i &&
             (last_tick + 1 == tick) &&
             (rs == last_rd || rt == last_rd));
    fl = hz.id_jump_i ||
         (hz.id_branch_i && hz.id_taken_i);
    m_sc = rst ? 16'h0 : 16'(scnt);
    if (rst)                 m_ctl = Z;
    else if (hz.dmem_busy_i) m_ctl = F;
    else if (stall)          m_ctl = S;
    else                     m_ctl = {2'b11, fl, 2'b00};
    if (tab_chk)
      check({nm, "_tab"},
            {act_ctl, hz.stall_cnt_o}, {t_ctl, t_sc});
    if (mdl_chk)
      check({nm, "_mdl"},
            {act_ctl, hz.stall_cnt_o}, {m_ctl, m_sc});
    if (rst) begin
      foreach (avail[i]) avail[i] = 0;
      tick = 0;
      last_tick = -10;
      last_rd = 0;
      scnt = 0;
    end else if (hz.dmem_busy_i) begin
      if (scnt < 65535) scnt++;
    end else if (stall) begin
      if (scnt < 65535) scnt++;
      tick++;
    end else begin
      if (hz.id_wr_i && rd != 0) begin
        avail[rd] = tick + 1 + m_lat(cls);
        last_tick = tick;
        last_rd = rd;
      end
      tick++;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [$];
  vec_t rv;

  initial begin
    n_tests = 0;
    n_fail = 0;
    foreach (avail[i]) avail[i] = 0;
    tick = 0;
    last_tick = -10;
    last_rd = 0;
    scnt = 0;

    // reset then release
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,Z,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,Z,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,N,0));
    // lw $2 ; add $3,$2,$4
    vecs.push_back(mk(0,0,0,0,2,1,1,0,0,0,0,N,0));
    vecs.push_back(mk(0,2,4,1,3,1,0,0,0,0,0,S,0));
    vecs.push_back(mk(0,2,4,1,3,1,0,0,0,0,0,N,1));
    // mul $5 ; add $6,$5,$5
    vecs.push_back(mk(0,0,0,0,5,1,2,0,0,0,0,N,1));
    vecs.push_back(mk(0,5,5,1,6,1,0,0,0,0,0,S,1));
    vecs.push_back(mk(0,5,5,1,6,1,0,0,0,0,0,S,2));
    vecs.push_back(mk(0,5,5,1,6,1,0,0,0,0,0,S,3));
    vecs.push_back(mk(0,5,5,1,6,1,0,0,0,0,0,N,4));
    // same with two frozen cycles mid-countdown
    vecs.push_back(mk(0,0,0,0,5,1,2,0,0,0,0,N,4));
    vecs.push_back(mk(0,5,5,1,6,1,0,0,0,0,0,S,4));
    vecs.push_back(mk(0,5,5,1,6,1,0,0,0,0,1,F,5));
    vecs.push_back(mk(0,5,5,1,6,1,0,0,0,0,1,F,6));
    vecs.push_back(mk(0,5,5,1,6,1,0,0,0,0,0,S,7));
    vecs.push_back(mk(0,5,5,1,6,1,0,0,0,0,0,S,8));
    vecs.push_back(mk(0,5,5,1,6,1,0,0,0,0,0,N,9));
    // add $7 ; beq $7,$0 taken ; jump
    vecs.push_back(mk(0,0,0,0,7,1,0,0,0,0,0,N,9));
    vecs.push_back(mk(0,7,0,1,0,0,0,1,1,0,0,S,9));
    vecs.push_back(mk(0,7,0,1,0,0,0,1,1,0,0,NF,10));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,NF,10));
    // lw $0 ; add $9,$0,$0
    vecs.push_back(mk(0,0,0,0,0,1,1,0,0,0,0,N,10));
    vecs.push_back(mk(0,0,0,1,9,1,0,0,0,0,0,N,10));
    // mul $8 ; addi $8 (WAW)
    vecs.push_back(mk(0,0,0,0,8,1,2,0,0,0,0,N,10));
    vecs.push_back(mk(0,0,0,0,8,1,0,0,0,0,0,S,10));
    vecs.push_back(mk(0,0,0,0,8,1,0,0,0,0,0,S,11));
    vecs.push_back(mk(0,0,0,0,8,1,0,0,0,0,0,S,12));
    vecs.push_back(mk(0,0,0,0,8,1,0,0,0,0,0,N,13));
    // mul $10 ; reset ; add $11,$10,$10
    vecs.push_back(mk(0,0,0,0,10,1,2,0,0,0,0,N,13));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,Z,0));
    vecs.push_back(mk(0,10,10,1,11,1,0,0,0,0,0,N,0));
    // reserved class acts as ALU
    vecs.push_back(mk(0,0,0,0,12,1,3,0,0,0,0,N,0));
    vecs.push_back(mk(0,12,12,1,13,1,0,0,0,0,0,N,0));
    // independent branch, not taken
    vecs.push_back(mk(0,1,2,1,0,0,0,1,0,0,0,N,0));

    drive(vecs[0]);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      step($sformatf("vec%0d", i), 1'b1,
           vecs[i].ctl, vecs[i].sc, 1'b1);
    end

    for (int i = 0; i < 1500; i++) begin
      rv.rst  = (i == 0) ||
                ($urandom_range(0, 59) == 0);
      rv.rs   = 5'($urandom_range(0, 7));
      rv.rt   = 5'($urandom_range(0, 7));
      rv.ut   = 1'($urandom_range(0, 1));
      rv.rd   = 5'($urandom_range(0, 7));
      rv.wr   = 1'($urandom_range(0, 1));
      rv.cls  = 2'($urandom_range(0, 3));
      rv.br   = ($urandom_range(0, 3) == 0);
      rv.tk   = 1'($urandom_range(0, 1));
      rv.jmp  = ($urandom_range(0, 9) == 0);
      rv.busy = ($urandom_range(0, 9) == 0);
      drive(rv);
      step("rand", 1'b0, Z, 16'h0, 1'b1);
    end

    drive(mk(1,0,0,0,0,0,0,0,0,0,0,Z,0));
    step("sat_rst", 1'b1, Z, 16'h0, 1'b1);
    drive(mk(0,0,0,0,0,0,0,0,0,0,1,F,0));
    for (int i = 0; i < 65536; i++)
      step("sat_run", 1'b0, Z, 16'h0, 1'b0);
    step("sat0", 1'b1, F, 16'hFFFF, 1'b1);
    step("sat1", 1'b1, F, 16'hFFFF, 1'b1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
